// File: rtl/piso_sipo_pkg.sv
// -----------------------------------------------------------------------------
// piso_sipo_pkg
// Shared definitions for the piso_sipo_link serialiser/deserialiser pair.
//   DEFAULT_WIDTH : default parallel word width
//   frame_len()   : number of serial-line cycles per frame (data bits, plus
//                   one parity bit when PISO_SIPO_PARITY_EN is defined)
//   TX_IDLE/TX_SHIFT, tx_state_e : transmitter state encoding
// Optional feature macro: PISO_SIPO_PARITY_EN
// -----------------------------------------------------------------------------
package piso_sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Transmitter states. The enum documents the encoding; the RTL stores the
    // state in a plain logic vector compared against these constants.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    // Serial cycles per frame for a given data width.
    function automatic int frame_len(input int width);
`ifdef PISO_SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx
// Parallel-in / serial-out transmitter. Accepts a word on a valid/ready
// handshake and shifts it out MSB first with a frame qualifier. With
// PISO_SIPO_PARITY_EN defined an even-parity bit follows the LSB.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   parallel_in   : word to transmit
//   in_valid      : parallel_in holds a valid word
//   in_ready      : a word can be accepted at the next rising edge
//   serial_out    : serial data line (registered)
//   serial_valid  : serial_out carries a frame bit (registered)
// -----------------------------------------------------------------------------
module piso_tx
    import piso_sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [0:0]       state_r;
    logic [WIDTH-1:0] data_r;      // bits still to be sent, next one at MSB
    logic [CNT_W-1:0] cnt_r;       // index of the bit currently on the line
    logic             ready_r;
    logic             so_r;
    logic             sv_r;
    logic             accept_s;
    logic             last_s;
    logic             next_bit_s;

`ifdef PISO_SIPO_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(WIDTH - 1);

    logic parity_r;

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign accept_s     = in_valid && ready_r;
    assign last_s       = (state_r == TX_SHIFT) && (cnt_r == LAST_IDX);
    assign in_ready     = ready_r;
    assign serial_out   = so_r;
    assign serial_valid = sv_r;

    // Select the bit to drive on the line at the next shift edge.
    always_comb begin
        next_bit_s = data_r[WIDTH-1];
`ifdef PISO_SIPO_PARITY_EN
        if (cnt_r == LAST_DATA_IDX) begin
            next_bit_s = parity_r;
        end else begin
            next_bit_s = data_r[WIDTH-1];
        end
`endif
    end

    // Handshake, load and shift sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= TX_IDLE;
            data_r   <= '0;
            cnt_r    <= CNT_ZERO;
            ready_r  <= 1'b0;
            so_r     <= 1'b0;
            sv_r     <= 1'b0;
`ifdef PISO_SIPO_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else if (accept_s) begin
            // MSB goes straight onto the line; the rest waits in data_r.
            state_r  <= TX_SHIFT;
            data_r   <= {parallel_in[WIDTH-2:0], 1'b0};
            cnt_r    <= CNT_ZERO;
            ready_r  <= 1'b0;
            so_r     <= parallel_in[WIDTH-1];
            sv_r     <= 1'b1;
`ifdef PISO_SIPO_PARITY_EN
            parity_r <= even_parity(parallel_in);
`endif
        end else begin
            case (state_r)
                TX_SHIFT: begin
                    if (last_s) begin
                        state_r <= TX_IDLE;
                        cnt_r   <= CNT_ZERO;
                        ready_r <= 1'b1;
                        so_r    <= 1'b0;
                        sv_r    <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        data_r  <= {data_r[WIDTH-2:0], 1'b0};
                        so_r    <= next_bit_s;
                        sv_r    <= 1'b1;
                        // Ready is raised while the final bit is on the line
                        // so the next frame can follow without a gap.
                        ready_r <= ((cnt_r + CNT_ONE) == LAST_IDX);
                    end
                end
                TX_IDLE: begin
                    ready_r <= 1'b1;
                    so_r    <= 1'b0;
                    sv_r    <= 1'b0;
                end
                default: begin
                    state_r <= TX_IDLE;
                    cnt_r   <= CNT_ZERO;
                    ready_r <= 1'b0;
                    so_r    <= 1'b0;
                    sv_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx
// Serial-in / parallel-out receiver. Shifts qualified line bits into the LSB
// of a register and, when a frame completes, loads parallel_out and pulses
// out_valid for one cycle. With PISO_SIPO_PARITY_EN defined the last frame
// bit is an even-parity bit that is checked, not stored.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   serial_in     : serial data line
//   serial_valid  : serial_in carries a frame bit
//   parallel_out  : last complete word, held between frames
//   out_valid     : one-cycle pulse when parallel_out updates
//   parity_err    : parity mismatch of the word flagged by out_valid
// -----------------------------------------------------------------------------
module sipo_rx
    import piso_sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             parity_err
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] cnt_r;       // number of frame bits captured so far
    logic [WIDTH-1:0] po_r;
    logic             ov_r;
    logic [WIDTH-1:0] word_s;
    logic             last_s;

`ifdef PISO_SIPO_PARITY_EN
    logic perr_r;

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

    assign last_s       = (cnt_r == LAST_IDX);
    assign parallel_out = po_r;
    assign out_valid    = ov_r;

    // Complete word as it stands on the final edge of a frame.
    always_comb begin
`ifdef PISO_SIPO_PARITY_EN
        // Final bit is parity; the data bits are already in shift_r.
        word_s = shift_r;
`else
        word_s = {shift_r[WIDTH-2:0], serial_in};
`endif
    end

    // Capture, count and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            cnt_r   <= CNT_ZERO;
            po_r    <= '0;
            ov_r    <= 1'b0;
`ifdef PISO_SIPO_PARITY_EN
            perr_r  <= 1'b0;
`endif
        end else if (serial_valid) begin
            if (last_s) begin
                // Counter wraps here, so a back-to-back frame loses no bit.
                shift_r <= word_s;
                cnt_r   <= CNT_ZERO;
                po_r    <= word_s;
                ov_r    <= 1'b1;
`ifdef PISO_SIPO_PARITY_EN
                perr_r  <= even_parity(shift_r) ^ serial_in;
`endif
            end else begin
                shift_r <= {shift_r[WIDTH-2:0], serial_in};
                cnt_r   <= cnt_r + CNT_ONE;
                ov_r    <= 1'b0;
            end
        end else begin
            ov_r <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_sipo_link.sv
// -----------------------------------------------------------------------------
// piso_sipo_link
// Serial link: piso_tx drives a 1-bit line (exported for observation) that
// feeds sipo_rx on the same clock.
// Ports:
//   clock, reset_n : clock (rising edge), asynchronous active-low reset
//   parallel_in    : word to transmit
//   in_valid       : parallel_in valid
//   in_ready       : transmitter accepts a word this cycle
//   serial_out     : serial line, MSB first
//   serial_valid   : serial line carries a frame bit
//   parallel_out   : last received word, held between frames
//   out_valid      : one-cycle pulse when parallel_out updates
//   parity_err     : parity mismatch (PISO_SIPO_PARITY_EN only, else 0)
// Optional feature macro: PISO_SIPO_PARITY_EN
// -----------------------------------------------------------------------------
module piso_sipo_link
    import piso_sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             parity_err
);

    piso_tx #(
        .WIDTH (WIDTH)
    ) u_tx (
        .clk          (clock),
        .rst_n        (reset_n),
        .parallel_in  (parallel_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid)
    );

    sipo_rx #(
        .WIDTH (WIDTH)
    ) u_rx (
        .clk          (clock),
        .rst_n        (reset_n),
        .serial_in    (serial_out),
        .serial_valid (serial_valid),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .parity_err   (parity_err)
    );

endmodule

// File: tb/tb_piso_sipo_link.sv
// -----------------------------------------------------------------------------
// tb_piso_sipo_link
// Self-checking bench for piso_sipo_link (WIDTH = 8). A queue-based reference
// model tracks the bits owed to the line and the bits received, and is
// compared against every DUT output each cycle; directed sequences add
// explicit checks for timing and corner cases.
// Optional feature macro: PISO_SIPO_PARITY_EN
// -----------------------------------------------------------------------------
module tb_piso_sipo_link;

    localparam int W = 8;
`ifdef PISO_SIPO_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic         clock;
    logic         reset_n;
    logic [W-1:0] parallel_in;
    logic         in_valid;
    logic         in_ready;
    logic         serial_out;
    logic         serial_valid;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         parity_err;

    piso_sipo_link #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .parallel_in  (parallel_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .parity_err   (parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;
    bit chk_en = 1'b1;

    // Reference model state
    bit           line_q[$];   // bits owed to the line
    bit           rx_q[$];     // bits received in the current frame
    logic         m_lv, m_lb, m_ready, m_ov, m_perr;
    logic [W-1:0] m_po;

    // Observation log of out_valid pulses
    int           ov_cyc[$];
    logic [W-1:0] ov_word[$];

    typedef struct {
        logic         iv;
        logic [W-1:0] din;
        logic         e_ready;
        logic         e_sv;
        logic         e_so;
        logic         e_ov;
        logic [W-1:0] e_po;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        rx_q.delete();
        m_lv = 1'b0; m_lb = 1'b0; m_ready = 1'b0;
        m_ov = 1'b0; m_perr = 1'b0; m_po = '0;
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_edge();
        logic [W-1:0] w;
        if (!reset_n) begin
            model_reset();
        end else begin
            // receiver sees the line value that was present before the edge
            m_ov = 1'b0;
            if (m_lv) begin
                rx_q.push_back(m_lb);
                if (rx_q.size() == N) begin
                    w = '0;
                    for (int i = 0; i < W; i++) w = {w[W-2:0], rx_q[i]};
                    m_po = w;
                    m_ov = 1'b1;
`ifdef PISO_SIPO_PARITY_EN
                    m_perr = (^w) ^ rx_q[W];
`endif
                    rx_q.delete();
                end
            end
            if (in_valid && m_ready) begin
                for (int i = W - 1; i >= 0; i--) line_q.push_back(parallel_in[i]);
`ifdef PISO_SIPO_PARITY_EN
                line_q.push_back(^parallel_in);
`endif
            end
            if (line_q.size() > 0) begin
                m_lv = 1'b1;
                m_lb = line_q.pop_front();
            end else begin
                m_lv = 1'b0;
                m_lb = 1'b0;
            end
            m_ready = (line_q.size() == 0);
        end
    endtask

    task automatic compare_all();
        if (chk_en) begin
            check("in_ready",     in_ready,     m_ready);
            check("serial_valid", serial_valid, m_lv);
            check("serial_out",   serial_out,   m_lb);
            check("out_valid",    out_valid,    m_ov);
            check("parallel_out", parallel_out, m_po);
            check("parity_err",   parity_err,   m_perr);
        end
    endtask

    // One clock cycle: drive inputs, edge, update model, sample at negedge.
    task automatic step(input logic iv, input logic [W-1:0] d);
        in_valid    = iv;
        parallel_in = d;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cycle++;
        compare_all();
        if (out_valid === 1'b1) begin
            ov_cyc.push_back(cycle);
            ov_word.push_back(parallel_out);
        end
    endtask

    task automatic async_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < cycles; i++) step(1'b0, '0);
        reset_n = 1'b1;
        step(1'b0, '0);
    endtask

    task automatic clear_log();
        ov_cyc.delete();
        ov_word.delete();
    endtask

    vec_t tbl[10];

    initial begin
        logic fb;
        int   base;

        model_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b1;
        parallel_in = 8'h55;

        // Reset held 3 cycles with in_valid high: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h55);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_serial_valid", serial_valid, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_parallel_out", parallel_out, 8'h00);
        end
        reset_n = 1'b1;
        step(1'b0, '0);
        check("in_ready_after_release", in_ready, 1'b1);
        step(1'b0, '0);

`ifndef PISO_SIPO_PARITY_EN
        // Single word 8'h0F: one record per cycle following the accept edge.
        tbl[0] = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].din);
            check($sformatf("tbl%0d_in_ready", i),     in_ready,     tbl[i].e_ready);
            check($sformatf("tbl%0d_serial_valid", i), serial_valid, tbl[i].e_sv);
            check($sformatf("tbl%0d_serial_out", i),   serial_out,   tbl[i].e_so);
            check($sformatf("tbl%0d_out_valid", i),    out_valid,    tbl[i].e_ov);
            check($sformatf("tbl%0d_parallel_out", i), parallel_out, tbl[i].e_po);
        end
`endif

        // Back-to-back 8'hA5 then 8'h3C with in_valid held.
        clear_log();
        step(1'b1, 8'hA5);
        base = cycle;
        for (int i = 1; i <= N; i++) step(1'b1, 8'h3C);
        for (int i = 0; i < N + 2; i++) step(1'b0, '0);
        check("b2b_pulses", ov_cyc.size(), 2);
        if (ov_cyc.size() == 2) begin
            check("b2b_first_latency", ov_cyc[0] - base, N);
            check("b2b_gap", ov_cyc[1] - ov_cyc[0], N);
            check("b2b_word0", ov_word[0], 8'hA5);
            check("b2b_word1", ov_word[1], 8'h3C);
        end

        // in_valid mid-frame with 8'hFF is ignored.
        clear_log();
        step(1'b1, 8'h5A);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, 8'hFF);
        check("busy_in_ready", in_ready, 1'b0);
        step(1'b1, 8'hFF);
        for (int i = 0; i < N + 2; i++) step(1'b0, '0);
        check("busy_pulses", ov_cyc.size(), 1);
        if (ov_cyc.size() == 1) check("busy_word", ov_word[0], 8'h5A);

        // Reset after 4 bits of 8'hC3, then 8'h81.
        clear_log();
        step(1'b1, 8'hC3);
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_parallel_out", parallel_out, 8'h00);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_serial_valid", serial_valid, 1'b0);
        step(1'b0, '0);
        step(1'b0, '0);
        reset_n = 1'b1;
        step(1'b0, '0);
        step(1'b1, 8'h81);
        for (int i = 0; i < N + 2; i++) step(1'b0, '0);
        check("midrst_pulses", ov_cyc.size(), 1);
        if (ov_cyc.size() == 1) check("midrst_word", ov_word[0], 8'h81);
        check("hold_parallel_out", parallel_out, 8'h81);

`ifdef PISO_SIPO_PARITY_EN
        // 8'h07: 9-bit frame, parity bit 1, parity_err 0.
        clear_log();
        step(1'b1, 8'h07);
        base = cycle;
        for (int i = 1; i < N; i++) step(1'b0, '0);
        check("par_bit_value", serial_out, 1'b1);
        check("par_bit_valid", serial_valid, 1'b1);
        step(1'b0, '0);
        check("par_out_valid", out_valid, 1'b1);
        check("par_latency", cycle - base, N);
        check("par_word", parallel_out, 8'h07);
        check("par_err_clean", parity_err, 1'b0);

        // Flip one line bit in flight: parity_err must be raised.
        step(1'b1, 8'h07);
        step(1'b0, '0);
        step(1'b0, '0);
        chk_en = 1'b0;
        fb = serial_out;
        force dut.serial_out = ~fb;
        step(1'b0, '0);
        release dut.serial_out;
        clear_log();
        for (int i = 0; i < N; i++) step(1'b0, '0);
        check("flip_pulses", ov_cyc.size(), 1);
        check("flip_parity_err", parity_err, 1'b1);
        chk_en = 1'b1;
        async_reset(2);
`endif

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset($urandom_range(1, 3));
            end else begin
                step(($urandom_range(0, 9) < 7), W'($urandom));
            end
        end
        for (int i = 0; i < N + 2; i++) step(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
